// File: rtl/portio_pkg.sv
// Shared constants for the MMIO port responder register window.
// Optional change detection is enabled with PORTIO_CHANGE_DETECT_EN.
package portio_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0100;

    localparam logic [3:0] OFF_PORTOUT = 4'h0;
    localparam logic [3:0] OFF_PORTIN  = 4'h4;
    localparam logic [3:0] OFF_STATUS  = 4'h8;
    localparam logic [3:0] OFF_TIMER   = 4'hC;

    localparam int CHG_BIT = 0;

    function automatic logic inWindow(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return (addr[31:4] == base[31:4]) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous input pins.
// Active-low asynchronous reset clears both stages.
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmio_port_responder.sv
// Four-word MMIO window: PORTOUT, PORTIN, STATUS, TIMER.
// Define PORTIO_CHANGE_DETECT_EN to build the CHG flag and Irq.
module mmio_port_responder
    import portio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         ReadData,
    output logic                Hit,
    output logic [31:0]         PortOut,
    output logic                Irq
);

    logic [IN_WIDTH-1:0] syncIn;
    logic [31:0]         timer;
    logic [31:0]         statusWord;
    logic                wrEn;

    sync_2ff #(
        .WIDTH(IN_WIDTH)
    ) uSync (
        .clk  (clk),
        .reset(reset),
        .d    (PortIn),
        .q    (syncIn)
    );

    assign Hit  = inWindow(Address, BASE_ADDR);
    assign wrEn = Hit && MemWrite;

    always_comb begin
        ReadData = '0;
        if (Hit && MemRead) begin
            unique case (Address[3:0])
                OFF_PORTOUT: ReadData = PortOut;
                OFF_PORTIN:  ReadData = 32'(syncIn);
                OFF_STATUS:  ReadData = statusWord;
                OFF_TIMER:   ReadData = timer;
                default:     ReadData = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PortOut <= '0;
        end else if (wrEn && Address[3:0] == OFF_PORTOUT) begin
            PortOut <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (wrEn && Address[3:0] == OFF_TIMER) begin
            timer <= WriteData;
        end else begin
            timer <= timer + 32'd1;
        end
    end

`ifdef PORTIO_CHANGE_DETECT_EN
    logic [IN_WIDTH-1:0] prevIn;
    logic                chg;
    logic                irqReg;
    logic                chgSet;
    logic                chgClr;

    assign chgSet = (syncIn != prevIn);
    assign chgClr = wrEn && (Address[3:0] == OFF_STATUS)
                 && WriteData[CHG_BIT];

    // Irq drops on the clearing edge so software sees both go low together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prevIn <= '0;
            chg    <= 1'b0;
            irqReg <= 1'b0;
        end else begin
            prevIn <= syncIn;
            chg    <= chgSet || (chg && !chgClr);
            irqReg <= chg && !chgClr;
        end
    end

    assign statusWord = 32'(chg) << CHG_BIT;
    assign Irq        = irqReg;
`else
    assign statusWord = '0;
    assign Irq        = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed, table-driven and randomized checks of mmio_port_responder.
// Expectations track PORTIO_CHANGE_DETECT_EN when it is defined.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE = 32'h1001_0100;
`ifdef PORTIO_CHANGE_DETECT_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        mw;
    logic        mr;
    logic [7:0]  pin;
    logic [31:0] rd;
    logic        hit;
    logic [31:0] pOut;
    logic        irq;

    int nVec = 0;
    int nErr = 0;

    mmio_port_responder #(
        .BASE_ADDR(BASE),
        .IN_WIDTH (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (addr),
        .WriteData(wd),
        .MemWrite (mw),
        .MemRead  (mr),
        .PortIn   (pin),
        .ReadData (rd),
        .Hit      (hit),
        .PortOut  (pOut),
        .Irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        r;
        logic        eHit;
        logic [31:0] eRd;
    } vec_t;

    vec_t tbl[10];

    logic [31:0] mPort, mTimer;
    logic        mChg, mIrq;
    logic [7:0]  hist[3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdChk(input string name, input logic [31:0] a,
                         input logic [31:0] exp);
        addr = a;
        mr   = 1'b1;
        mw   = 1'b0;
        #1;
        chk(name, rd, exp);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        mw   = 1'b1;
        mr   = 1'b1;
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] a,
                                              input logic r);
        logic [31:0] v;
        logic        h;
        h = (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00);
        case (a[3:2])
            2'd0: v = mPort;
            2'd1: v = {24'd0, hist[1]};
            2'd2: v = {31'd0, mChg};
            default: v = mTimer;
        endcase
        return (h && r) ? v : 32'd0;
    endfunction

    task automatic modelEdge();
        logic h, w, clr, set;
        logic [1:0] off;
        h   = (addr[31:4] == BASE[31:4]) && (addr[1:0] == 2'b00);
        w   = h && mw;
        off = addr[3:2];
        clr = CD_EN && w && off == 2'd2 && wd[0];
        set = CD_EN && (hist[1] != hist[2]);
        mIrq   = CD_EN && mChg && !clr;
        mChg   = set || (mChg && !clr);
        mTimer = (w && off == 2'd3) ? wd : mTimer + 32'd1;
        if (w && off == 2'd0) mPort = wd;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = pin;
    endtask

    initial begin
        reset = 1'b0;
        addr  = BASE;
        wd    = '0;
        mw    = 1'b0;
        mr    = 1'b1;
        pin   = 8'h00;
        tick();
        tick();
        #1;
        chk("rst_portout", pOut, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_hit", {31'd0, hit}, 32'd1);
        reset = 1'b1;
        rdChk("timer_0", BASE + 32'hC, 32'd0);
        tick();
        rdChk("timer_1", BASE + 32'hC, 32'd1);
        rdChk("status_rst", BASE + 32'h8, 32'd0);

        store(BASE, 32'hA5A5_0F0F);
        #1;
        chk("rw_prewrite", rd, 32'd0);
        tick();
        mw = 1'b0;
        #1;
        chk("portout_store", pOut, 32'hA5A5_0F0F);
        rdChk("portout_load", BASE, 32'hA5A5_0F0F);
        store(BASE + 32'h4, 32'hFFFF_FFFF);
        tick();
        rdChk("portin_ro", BASE + 32'h4, 32'd0);
        chk("portout_keep", pOut, 32'hA5A5_0F0F);

        pin = 8'h3C;
        tick();
        rdChk("portin_e1", BASE + 32'h4, 32'd0);
        tick();
        rdChk("portin_e2", BASE + 32'h4, 32'h3C);
        rdChk("chg_e2", BASE + 32'h8, 32'd0);
        tick();
        rdChk("chg_e3", BASE + 32'h8, 32'(CD_EN));
        chk("irq_e3", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_e4", {31'd0, irq}, 32'(CD_EN));

        store(BASE + 32'h8, 32'd1);
        #1;
        chk("w1c_prewrite", rd, 32'(CD_EN));
        tick();
        mw  = 1'b0;
        pin = 8'h55;
        rdChk("w1c_chg", BASE + 32'h8, 32'd0);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        tick();
        tick();
        store(BASE + 32'h8, 32'd1);
        tick();
        rdChk("set_beats_clr", BASE + 32'h8, 32'(CD_EN));
        tick();
        chk("irq_after_race", {31'd0, irq}, 32'(CD_EN));

        store(BASE + 32'hC, 32'hFFFF_FFFE);
        tick();
        rdChk("tload", BASE + 32'hC, 32'hFFFF_FFFE);
        tick();
        rdChk("tload_p1", BASE + 32'hC, 32'hFFFF_FFFF);
        tick();
        rdChk("twrap", BASE + 32'hC, 32'd0);
        tick();
        rdChk("twrap_p1", BASE + 32'hC, 32'd1);

        store(BASE + 32'h2, 32'h1234_5678);
        #1;
        chk("unal_hit", {31'd0, hit}, 32'd0);
        chk("unal_rd", rd, 32'd0);
        tick();
        mw = 1'b0;
        #1;
        chk("unal_nowrite", pOut, 32'hA5A5_0F0F);
        rdChk("unal_portin", BASE + 32'h4, 32'h55);

        tbl[0] = '{BASE,                1'b1, 1'b1, 32'hA5A5_0F0F};
        tbl[1] = '{BASE,                1'b0, 1'b1, 32'd0};
        tbl[2] = '{BASE + 32'h4,        1'b1, 1'b1, 32'h55};
        tbl[3] = '{BASE + 32'h8,        1'b1, 1'b1, 32'(CD_EN)};
        tbl[4] = '{BASE + 32'h1,        1'b1, 1'b0, 32'd0};
        tbl[5] = '{BASE + 32'h7,        1'b1, 1'b0, 32'd0};
        tbl[6] = '{BASE + 32'h10,       1'b1, 1'b0, 32'd0};
        tbl[7] = '{BASE - 32'h4,        1'b1, 1'b0, 32'd0};
        tbl[8] = '{BASE ^ 32'h0000_0100, 1'b1, 1'b0, 32'd0};
        tbl[9] = '{BASE ^ 32'h8000_0000, 1'b1, 1'b0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            addr = tbl[i].a;
            mr   = tbl[i].r;
            mw   = 1'b0;
            #1;
            chk($sformatf("tbl%0d_hit", i), {31'd0, hit},
                {31'd0, tbl[i].eHit});
            chk($sformatf("tbl%0d_rd", i), rd, tbl[i].eRd);
        end

        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_portout", pOut, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        rdChk("arst_timer", BASE + 32'hC, 32'd0);
        rdChk("arst_status", BASE + 32'h8, 32'd0);
        rdChk("arst_portin", BASE + 32'h4, 32'd0);
        tick();
        reset = 1'b1;

        mPort  = '0;
        mTimer = '0;
        mChg   = 1'b0;
        mIrq   = 1'b0;
        hist   = '{8'd0, 8'd0, 8'd0};
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) != 0)
                addr = BASE + 32'($urandom_range(0, 15));
            else
                addr = BASE ^ (32'd1 << $urandom_range(4, 31));
            wd = $urandom;
            if ($urandom_range(0, 1) == 1) wd[0] = 1'b1;
            mw = ($urandom_range(0, 3) == 0);
            mr = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) pin = 8'($urandom);
            #1;
            chk("rnd_hit", {31'd0, hit},
                {31'd0, (addr[31:4] == BASE[31:4]) && (addr[1:0] == 2'b00)});
            chk("rnd_rd", rd, modelRead(addr, mr));
            chk("rnd_portout", pOut, mPort);
            chk("rnd_irq", {31'd0, irq}, {31'd0, mIrq});
            tick();
            modelEdge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
